// File: rtl/bnn_pkg.sv
// Shared sizes and types for the binary network datapath.
// Conv2 produces an 11x11x16 binary map; pool2 reduces it to 5x5x16.
package bnn_pkg;
    localparam int CONV2_CH    = 16;
    localparam int CONV2_OUT_W = 11;
    localparam int CONV2_OUT_H = 11;
    localparam int POOL2_OUT_W = 5;
    localparam int POOL2_OUT_H = 5;

    typedef logic [CONV2_CH-1:0] conv2_vec_t;
endpackage

// File: rtl/pool_row_buf.sv
// Holds the horizontally-ORed pairs of an even row until the odd row arrives.
// Write is registered, read is combinational so the pool output keeps 1-cycle latency.
module pool_row_buf #(
    parameter int DEPTH = 5,
    parameter int W     = 16,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_dat_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_dat_o
);
    // No reset: every entry is written during the even row before it is read.
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_addr_i];
endmodule

// File: rtl/conv2_pool.sv
// 2x2 stride-2 binary max-pool (per-channel OR) over the raster conv2 stream.
// One registered output per window, 1 cycle after its bottom-right beat; no backpressure.
module conv2_pool
    import bnn_pkg::*;
#(
    parameter int CH   = CONV2_CH,
    parameter int IN_W = CONV2_OUT_W,
    parameter int IN_H = CONV2_OUT_H
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in_conv2,
    input  logic [CH-1:0] conv2_in,
    output logic [CH-1:0] pool_out,
    output logic          valid_out_pool,
    output logic          frame_done
);
    localparam int OUT_W = IN_W / 2;
    localparam int OUT_H = IN_H / 2;
    localparam int CW    = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int RW    = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int AW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [CH-1:0] h_q, h_d;
    logic [CH-1:0] pool_q, pool_d;
    logic          vld_q, vld_d;
    logic          done_q, done_d;

    logic          col_last, row_last, col_pair, row_pair;
    logic [CH-1:0] h_or, rb_rd_dat;
    logic [AW-1:0] rb_addr;
    logic          rb_wr_en;

    assign col_last = (col_q == CW'(IN_W - 1));
    assign row_last = (row_q == RW'(IN_H - 1));
    // One extra bit so 2*OUT_W still fits when IN_W is an exact power of two.
    assign col_pair = ({1'b0, col_q} < (CW + 1)'(2 * OUT_W));
    assign row_pair = ({1'b0, row_q} < (RW + 1)'(2 * OUT_H));
    assign h_or     = h_q | conv2_in;
    assign rb_addr  = AW'(col_q >> 1);

    pool_row_buf #(
        .DEPTH (OUT_W),
        .W     (CH),
        .AW    (AW)
    ) u_row_buf (
        .clk       (clk),
        .wr_en_i   (rb_wr_en),
        .wr_addr_i (rb_addr),
        .wr_dat_i  (h_or),
        .rd_addr_i (rb_addr),
        .rd_dat_o  (rb_rd_dat)
    );

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        h_d      = h_q;
        pool_d   = '0;
        vld_d    = 1'b0;
        done_d   = 1'b0;
        rb_wr_en = 1'b0;
        if (valid_in_conv2) begin
            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d  = '0;
                    done_d = 1'b1;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
            // Unpaired last column/row fall outside the pair window and are dropped.
            if (col_pair) begin
                if (!col_q[0]) begin
                    h_d = conv2_in;
                end else if (row_pair) begin
                    if (!row_q[0]) begin
                        rb_wr_en = 1'b1;
                    end else begin
                        pool_d = rb_rd_dat | h_or;
                        vld_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            h_q    <= '0;
            pool_q <= '0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            h_q    <= h_d;
            pool_q <= pool_d;
            vld_q  <= vld_d;
            done_q <= done_d;
        end
    end

    assign pool_out       = pool_q;
    assign valid_out_pool = vld_q;
    assign frame_done     = done_q;
endmodule
